// File: rtl/seg_scan_ctrl_if.sv
// Bus bundle for seg_scan_ctrl: load handshake, display data and the multiplexed
// anode/segment drive. The master side drives data in; the slave is the controller.
interface seg_scan_ctrl_if;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  en_mask;
    logic        ready;
    logic        frame_done;
    logic        AN0;
    logic        AN1;
    logic        AN2;
    logic        AN3;
    logic [6:0]  LEDout;
    logic        DP;

    modport master (
        output load, digits_in, dp_in, en_mask,
        input  ready, frame_done, AN0, AN1, AN2, AN3, LEDout, DP
    );

    modport slave (
        input  load, digits_in, dp_in, en_mask,
        output ready, frame_done, AN0, AN1, AN2, AN3, LEDout, DP
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with frame-synchronous data update.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zeros on digits 3..1.
module seg_scan_ctrl #(
    parameter int unsigned DIV_WIDTH    = 16,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input logic            clk_in,
    input logic            rst,
    seg_scan_ctrl_if.slave bus
);
    localparam int unsigned   CW         = (DIV_WIDTH > 8) ? DIV_WIDTH : 8;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DRIVE_LAST = CW'((64'd1 << DIV_WIDTH) - 64'd1);

    typedef enum logic {
        BLANK,
        DRIVE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          boundary;

    logic [15:0]   sh_digits, pend_digits;
    logic [3:0]    sh_dp, pend_dp;
    logic [3:0]    sh_en, pend_en;
    logic          pend_valid;

    logic [3:0]    an_q, an_d;
    logic [6:0]    led_q, led_d;
    logic          dp_q, dp_d;
    logic [3:0]    nib;
    logic          show;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= BLANK;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q + 1'b1;
        boundary = 1'b0;
        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == DRIVE_LAST) begin
                    state_d  = BLANK;
                    cnt_d    = '0;
                    idx_d    = idx_q + 2'd1;
                    boundary = (idx_q == 2'd3);
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // A pending update only lands on the frame boundary; a load taken on the
    // boundary itself finds pend_valid low there and so waits a full frame.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sh_digits   <= '0;
            sh_dp       <= '0;
            sh_en       <= '0;
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_en     <= '0;
            pend_valid  <= 1'b0;
        end else if (boundary && pend_valid) begin
            sh_digits  <= pend_digits;
            sh_dp      <= pend_dp;
            sh_en      <= pend_en;
            pend_valid <= 1'b0;
        end else if (bus.load && !pend_valid) begin
            pend_digits <= bus.digits_in;
            pend_dp     <= bus.dp_in;
            pend_en     <= bus.en_mask;
            pend_valid  <= 1'b1;
        end
    end

    assign nib = sh_digits[{idx_d, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] zero_or_off;
    logic [3:0] lead_zero;
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            zero_or_off[i] = ~sh_en[i] | (sh_digits[4*i +: 4] == 4'h0);
        end
        lead_zero[3] = (sh_digits[15:12] == 4'h0);
        lead_zero[2] = (sh_digits[11:8] == 4'h0) & zero_or_off[3];
        lead_zero[1] = (sh_digits[7:4] == 4'h0) & zero_or_off[3] & zero_or_off[2];
        lead_zero[0] = 1'b0;
        show         = ~lead_zero[idx_d];
    end
`else
    assign show = 1'b1;
`endif

    // Outputs are computed from the next state so the registered drive lines up
    // with the FSM state in the same cycle.
    always_comb begin
        an_d  = 4'hF;
        led_d = 7'h7F;
        dp_d  = 1'b1;
        if (state_d == DRIVE && sh_en[idx_d]) begin
            if (show) begin
                an_d[idx_d] = 1'b0;
                led_d       = hex_glyph(nib);
                dp_d        = ~sh_dp[idx_d];
            end else if (sh_dp[idx_d]) begin
                an_d[idx_d] = 1'b0;
                dp_d        = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            an_q  <= 4'hF;
            led_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            led_q <= led_d;
            dp_q  <= dp_d;
        end
    end

    assign bus.ready      = ~pend_valid;
    assign bus.frame_done = boundary;
    assign bus.AN0        = an_q[0];
    assign bus.AN1        = an_q[1];
    assign bus.AN2        = an_q[2];
    assign bus.AN3        = an_q[3];
    assign bus.LEDout     = led_q;
    assign bus.DP         = dp_q;
endmodule
